// File: rtl/fp32_dot_accumulator_if.sv
// Handshake bundle between the FP32 multiplier stage and the dot-product accumulator.
// The master drives products and takes sums; the slave is the accumulator.
interface fp32_dot_accumulator_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fp32_dot_accumulator.sv
// FP32 running-sum accumulator for a systolic PE column: one product every three cycles,
// truncating rounding, no denormals, emits the sum when an element is tagged last.
module fp32_dot_accumulator (
  input  logic                        clk,
  input  logic                        reset,
  fp32_dot_accumulator_if.slave       io_bus
);

  typedef enum logic [1:0] {
    ACC,
    ALIGN,
    NORM,
    OUT
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [31:0] r_acc;
  logic [31:0] r_opnd;
  logic        r_last;

  logic        r_bigSign;
  logic [7:0]  r_bigExp;
  logic [23:0] r_bigMant;
  logic [23:0] r_smlMant;
  logic        r_subtract;

  logic        w_inFire;
  logic        w_outFire;

  logic [7:0]  w_accExp;
  logic [7:0]  w_opExp;
  logic [23:0] w_accMant;
  logic [23:0] w_opMant;
  logic        w_accIsBig;
  logic [7:0]  w_expDiff;
  logic [23:0] w_smlRaw;
  logic [23:0] w_smlShifted;

  logic [24:0]       w_sum;
  logic [4:0]        w_lzc;
  logic [23:0]       w_normMant;
  logic signed [9:0] w_normExp;
  logic [22:0]       w_frac;
  logic [31:0]       w_result;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    lzc24 = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) lzc24 = 5'(23 - i);
    end
  endfunction

  assign w_inFire  = (r_state == ACC) && io_bus.in_valid;
  assign w_outFire = (r_state == OUT) && io_bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ACC;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState      = r_state;
    io_bus.in_ready  = 1'b0;
    io_bus.out_valid = 1'b0;
    io_bus.out_data  = 32'h0;
    case (r_state)
      ACC: begin
        io_bus.in_ready = 1'b1;
        if (io_bus.in_valid) w_nextState = ALIGN;
      end
      ALIGN: w_nextState = NORM;
      NORM:  w_nextState = r_last ? OUT : ACC;
      OUT: begin
        io_bus.out_valid = 1'b1;
        io_bus.out_data  = r_acc;
        if (io_bus.out_ready) w_nextState = ACC;
      end
      default: w_nextState = ACC;
    endcase
  end

  // Zero exponent means zero; magnitude compare includes the mantissa so subtraction never underflows.
  always_comb begin
    w_accExp     = r_acc[30:23];
    w_opExp      = r_opnd[30:23];
    w_accMant    = (w_accExp == 8'd0) ? 24'd0 : {1'b1, r_acc[22:0]};
    w_opMant     = (w_opExp == 8'd0) ? 24'd0 : {1'b1, r_opnd[22:0]};
    w_accIsBig   = {w_accExp, w_accMant} >= {w_opExp, w_opMant};
    w_expDiff    = w_accIsBig ? (w_accExp - w_opExp) : (w_opExp - w_accExp);
    w_smlRaw     = w_accIsBig ? w_opMant : w_accMant;
    w_smlShifted = (w_expDiff >= 8'd25) ? 24'd0 : (w_smlRaw >> w_expDiff);
  end

  always_comb begin
    if (r_subtract) w_sum = {1'b0, r_bigMant} - {1'b0, r_smlMant};
    else            w_sum = {1'b0, r_bigMant} + {1'b0, r_smlMant};
    w_lzc      = lzc24(w_sum[23:0]);
    w_normMant = w_sum[23:0] << w_lzc;
    if (w_sum[24]) begin
      w_normExp = $signed({2'b00, r_bigExp}) + 10'sd1;
      w_frac    = w_sum[23:1];
    end else begin
      w_normExp = $signed({2'b00, r_bigExp}) - $signed({5'b00000, w_lzc});
      w_frac    = w_normMant[22:0];
    end
    if (w_sum == 25'd0)              w_result = 32'h0;
    else if (w_normExp <= 10'sd0)    w_result = {r_bigSign, 31'h0};
    else if (w_normExp >= 10'sd255)  w_result = {r_bigSign, 8'hFF, 23'h0};
    else                             w_result = {r_bigSign, w_normExp[7:0], w_frac};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= 32'h0;
      r_opnd     <= 32'h0;
      r_last     <= 1'b0;
      r_bigSign  <= 1'b0;
      r_bigExp   <= 8'd0;
      r_bigMant  <= 24'd0;
      r_smlMant  <= 24'd0;
      r_subtract <= 1'b0;
    end else begin
      if (w_inFire) begin
        r_opnd <= io_bus.in_data;
        r_last <= io_bus.in_last;
      end
      if (r_state == ALIGN) begin
        r_bigSign  <= w_accIsBig ? r_acc[31] : r_opnd[31];
        r_bigExp   <= w_accIsBig ? w_accExp : w_opExp;
        r_bigMant  <= w_accIsBig ? w_accMant : w_opMant;
        r_smlMant  <= w_smlShifted;
        r_subtract <= r_acc[31] ^ r_opnd[31];
      end
      if (r_state == NORM) r_acc <= w_result;
      // The held sum is consumed on the output handshake, so the next dot product starts at zero.
      if (w_outFire) r_acc <= 32'h0;
    end
  end

endmodule

// File: tb/tb_fp32_dot_accumulator.sv
// Directed bench for fp32_dot_accumulator: expected sums go to a scoreboard queue and a
// monitor pops them on every output handshake.
module tb_fp32_dot_accumulator;
  logic clk;
  logic reset;

  fp32_dot_accumulator_if bus ();

  fp32_dot_accumulator dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] expQ[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drives one word, waits for the handshake, then checks the 3-cycle ready pattern.
  task automatic applyStimulus(input logic [31:0] d, input logic l, input logic [31:0] expSum);
    int waitCycles;
    waitCycles = 0;
    if (l) expQ.push_back(expSum);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!bus.in_ready) begin
      checkOutput("handshakeTimeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'hDEAD_BEEF;
    bus.in_last  = 1'b0;
    @(negedge clk);
    checkOutput("readyLowT1", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    checkOutput("readyLowT2", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    checkOutput("readyT3", {31'd0, bus.in_ready}, {31'd0, !l});
    if (l) checkOutput("validT3", {31'd0, bus.out_valid}, 32'd1);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid && bus.out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedSum", bus.out_data, 32'hXXXX_XXXX);
        end else begin
          checkOutput("sum", bus.out_data, expQ.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rstInReady", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("rstOutValid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rstOutData", bus.out_data, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("idleInReady", {31'd0, bus.in_ready}, 32'd1);

    // 1 + 2 + 3 = 6
    applyStimulus(32'h3F80_0000, 1'b0, 32'h0);
    applyStimulus(32'h4000_0000, 1'b0, 32'h0);
    applyStimulus(32'h4040_0000, 1'b1, 32'h40C0_0000);
    // Exact cancellation gives +0
    applyStimulus(32'h3F80_0000, 1'b0, 32'h0);
    applyStimulus(32'hBF80_0000, 1'b1, 32'h0000_0000);
    // 2^24 + 1 truncates to 2^24
    applyStimulus(32'h4B80_0000, 1'b0, 32'h0);
    applyStimulus(32'h3F80_0000, 1'b1, 32'h4B80_0000);
    // Overflow saturates to +inf
    applyStimulus(32'h7F00_0000, 1'b0, 32'h0);
    applyStimulus(32'h7F00_0000, 1'b1, 32'h7F80_0000);
    // Denormal input treated as zero
    applyStimulus(32'h0040_0000, 1'b0, 32'h0);
    applyStimulus(32'h3F00_0000, 1'b1, 32'h3F00_0000);
    // 5 + (-3) = 2 needs a one-bit left normalisation
    applyStimulus(32'h40A0_0000, 1'b0, 32'h0);
    applyStimulus(32'hC040_0000, 1'b1, 32'h4000_0000);
    // 2^-126 - 1.5*2^-126 underflows to -0
    applyStimulus(32'h0080_0000, 1'b0, 32'h0);
    applyStimulus(32'h80C0_0000, 1'b1, 32'h8000_0000);

    // Output stall: sum must stay put and input stays blocked
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    applyStimulus(32'h3F80_0000, 1'b0, 32'h0);
    applyStimulus(32'h4000_0000, 1'b1, 32'h4040_0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stallValid", {31'd0, bus.out_valid}, 32'd1);
      checkOutput("stallData", bus.out_data, 32'h4040_0000);
      checkOutput("stallReady", {31'd0, bus.in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    applyStimulus(32'h3F80_0000, 1'b1, 32'h3F80_0000);

    // Reset while in ALIGN discards the in-flight element
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h4080_0000;
    bus.in_last  = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("midRstInReady", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("midRstOutValid", {31'd0, bus.out_valid}, 32'd0);
    applyStimulus(32'h4000_0000, 1'b1, 32'h4000_0000);

    repeat (5) @(negedge clk);
    checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
